// File: rtl/branch_gshare_spec_pkg.sv
// branch_pred_pkg: shared types and helpers for the GShare direction predictor.
//   - hist_src_e    : which source loads the speculative GHR in a given cycle
//   - cnt_reset_val : weak not-taken reset value for a CNT_W-bit counter
//   - cnt_sat_step  : saturating +1/-1 for a CNT_W-bit counter
// Counters are handled in a CNT_MAX_W-bit container so one function serves
// every legal CNT_W (2..4); callers cast to their own width.
package branch_pred_pkg;

    localparam int CNT_MAX_W = 4;

    typedef enum logic [1:0] {
        HIST_NONE,
        HIST_SPEC,
        HIST_MISPRED,
        HIST_FLUSH
    } hist_src_e;

    function automatic logic [CNT_MAX_W-1:0] cnt_reset_val(input int cnt_w);
        return CNT_MAX_W'((1 << (cnt_w - 1)) - 1);
    endfunction

    function automatic logic [CNT_MAX_W-1:0] cnt_sat_step(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 inc,
        input int                   cnt_w
    );
        logic [CNT_MAX_W-1:0] max_val;
        max_val = CNT_MAX_W'((1 << cnt_w) - 1);
        if (inc)
            return (cnt == max_val) ? cnt : cnt + CNT_MAX_W'(1);
        else
            return (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/branch_gshare_spec_if.sv
// branch_gshare_spec_if: fetch-side lookup and EX-side training signals.
//   master (pipeline): drives pc_if, if_br_valid, if_stall, ex_update_en,
//                      ex_actual_taken, ex_mispredict, pht_idx_ex, flush;
//                      receives pred_taken_if, pht_idx_if.
//   slave (predictor): the mirror image.
interface branch_gshare_spec_if #(
    parameter int IDX_W = 10
) ();
    logic [31:0]      pc_if;
    logic             if_br_valid;
    logic             if_stall;
    logic             pred_taken_if;
    logic [IDX_W-1:0] pht_idx_if;
    logic             ex_update_en;
    logic             ex_actual_taken;
    logic             ex_mispredict;
    logic [IDX_W-1:0] pht_idx_ex;
    logic             flush;

    modport master (
        output pc_if, if_br_valid, if_stall,
        output ex_update_en, ex_actual_taken, ex_mispredict, pht_idx_ex, flush,
        input  pred_taken_if, pht_idx_if
    );

    modport slave (
        input  pc_if, if_br_valid, if_stall,
        input  ex_update_en, ex_actual_taken, ex_mispredict, pht_idx_ex, flush,
        output pred_taken_if, pht_idx_if
    );
endinterface

// File: rtl/branch_gshare_spec_pht.sv
// gshare_pht: pattern history table of CNT_W-bit saturating counters.
//   clk, rst     : clock, async active-high reset (all counters -> weak not-taken)
//   rd_idx       : IF lookup index (async read)
//   rd_taken     : MSB of the addressed counter
//   wr_en        : EX training strobe
//   wr_taken     : resolved direction (+1 taken, -1 not taken)
//   wr_idx       : EX training index
// The read port sees the registered array only, so a same-cycle write is
// visible to IF one cycle later.
module gshare_pht
    import branch_pred_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic             wr_taken,
    input  logic [IDX_W-1:0] wr_idx
);
    localparam int DEPTH = 1 << IDX_W;

    logic [CNT_W-1:0] cnt [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= CNT_W'(cnt_reset_val(CNT_W));
        end else if (wr_en) begin
            cnt[wr_idx] <= CNT_W'(cnt_sat_step(CNT_MAX_W'(cnt[wr_idx]), wr_taken, CNT_W));
        end
    end

    assign rd_taken = cnt[rd_idx][CNT_W-1];
endmodule

// File: rtl/branch_gshare_spec.sv
// branch_gshare_spec: GShare direction predictor between IF and EX.
//   clk, rst : clock, async active-high reset
//   bp       : branch_gshare_spec_if.slave (lookup at IF, training/repair at EX)
//   stat_*   : lookup / update / mispredict counters, present only when
//              GSHARE_STATS_EN is defined
// IF index = PC[PC_LSB+IDX_W-1:PC_LSB] ^ zext(spec_ghr). The speculative GHR
// shifts in each consumed prediction; EX keeps an exact architectural GHR and
// copies its next value into spec_ghr on a mispredict or a flush.
module branch_gshare_spec
    import branch_pred_pkg::*;
#(
    parameter int PC_LSB = 2,
    parameter int IDX_W  = 10,
    parameter int HIST_W = 10,
    parameter int CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    branch_gshare_spec_if.slave        bp
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]                stat_lookups,
    output logic [31:0]                stat_updates,
    output logic [31:0]                stat_mispredicts
`endif
);
    logic [HIST_W-1:0] spec_ghr;
    logic [HIST_W-1:0] arch_ghr;
    logic [HIST_W-1:0] arch_ghr_nxt;
    logic [HIST_W-1:0] spec_shift;
    logic [IDX_W-1:0]  idx_if;
    logic              pred;
    logic              consume;
    logic              mispred;
    hist_src_e         src;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_if[31:PC_LSB+IDX_W], bp.pc_if[PC_LSB-1:0]};

    assign idx_if        = bp.pc_if[PC_LSB+IDX_W-1:PC_LSB] ^ IDX_W'(spec_ghr);
    assign bp.pht_idx_if = idx_if;
    assign bp.pred_taken_if = pred;

    assign consume = bp.if_br_valid && !bp.if_stall;
    assign mispred = bp.ex_update_en && bp.ex_mispredict;

    // Truncating the concatenation keeps the low HIST_W bits, which is a
    // left shift that also covers HIST_W == 1.
    assign spec_shift   = HIST_W'({spec_ghr, pred});
    assign arch_ghr_nxt = bp.ex_update_en ? HIST_W'({arch_ghr, bp.ex_actual_taken}) : arch_ghr;

    always_comb begin
        src = HIST_NONE;
        if (mispred)
            src = HIST_MISPRED;
        else if (bp.flush)
            src = HIST_FLUSH;
        else if (consume)
            src = HIST_SPEC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            arch_ghr <= arch_ghr_nxt;
            case (src)
                HIST_MISPRED, HIST_FLUSH: spec_ghr <= arch_ghr_nxt;
                HIST_SPEC:                spec_ghr <= spec_shift;
                default:                  spec_ghr <= spec_ghr;
            endcase
        end
    end

    gshare_pht #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_if),
        .rd_taken (pred),
        .wr_en    (bp.ex_update_en),
        .wr_taken (bp.ex_actual_taken),
        .wr_idx   (bp.pht_idx_ex)
    );

`ifdef GSHARE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (consume)         stat_lookups     <= stat_lookups + 32'd1;
            if (bp.ex_update_en) stat_updates     <= stat_updates + 32'd1;
            if (mispred)         stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_gshare_spec.sv
// Testbench for branch_gshare_spec: directed scenarios followed by random
// traffic, checked against a behavioural model (counter array + two
// histories held as integers).
module tb_branch_gshare_spec;
    logic clk;
    logic rst;

    branch_gshare_spec_if #(.IDX_W(10)) bp ();

`ifdef GSHARE_STATS_EN
    logic [31:0] stat_lookups, stat_updates, stat_mispredicts;
`endif

    branch_gshare_spec #(
        .PC_LSB (2),
        .IDX_W  (10),
        .HIST_W (10),
        .CNT_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
`ifdef GSHARE_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int m_pht [1024];
    int m_spec;
    int m_arch;
    int m_lookups, m_updates, m_mispreds;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_pht[i] = 1;
        m_spec = 0;
        m_arch = 0;
        m_lookups = 0;
        m_updates = 0;
        m_mispreds = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic br, input logic stall,
                         input logic upd, input logic act, input logic mis,
                         input logic [9:0] exi, input logic fl);
        bp.pc_if           = pc;
        bp.if_br_valid     = br;
        bp.if_stall        = stall;
        bp.ex_update_en    = upd;
        bp.ex_actual_taken = act;
        bp.ex_mispredict   = mis;
        bp.pht_idx_ex      = exi;
        bp.flush           = fl;
    endtask

    // One clock cycle: drive, check IF outputs, advance the model, clock.
    task automatic step(input logic [31:0] pc, input logic br, input logic stall,
                        input logic upd, input logic act, input logic mis,
                        input logic [9:0] exi, input logic fl);
        int idx, pred, arch_new;
        drive(pc, br, stall, upd, act, mis, exi, fl);
        #1;
        idx  = int'(pc[11:2]) ^ m_spec;
        pred = (m_pht[idx] >= 2) ? 1 : 0;
        chk("pht_idx_if", 32'(bp.pht_idx_if), 32'(idx));
        chk("pred_taken_if", 32'(bp.pred_taken_if), 32'(pred));
        arch_new = upd ? (((m_arch * 2) + int'(act)) % 1024) : m_arch;
        if (upd) begin
            if (act) m_pht[exi] = (m_pht[exi] == 3) ? 3 : m_pht[exi] + 1;
            else     m_pht[exi] = (m_pht[exi] == 0) ? 0 : m_pht[exi] - 1;
            m_updates++;
            if (mis) m_mispreds++;
        end
        if (br && !stall) m_lookups++;
        if (upd && mis)        m_spec = arch_new;
        else if (fl)           m_spec = arch_new;
        else if (br && !stall) m_spec = ((m_spec * 2) + pred) % 1024;
        m_arch = arch_new;
        @(posedge clk);
        @(negedge clk);
`ifdef GSHARE_STATS_EN
        chk("stat_lookups", stat_lookups, 32'(m_lookups));
        chk("stat_updates", stat_updates, 32'(m_updates));
        chk("stat_mispredicts", stat_mispredicts, 32'(m_mispreds));
`endif
    endtask

    task automatic upd_only(input logic [9:0] exi, input logic act);
        step(32'h104, 1'b0, 1'b0, 1'b1, act, 1'b0, exi, 1'b0);
    endtask

    // Shift a 10-bit pattern (MSB first) into the architectural history.
    task automatic load_arch(input logic [9:0] pattern);
        for (int i = 9; i >= 0; i--) upd_only(10'h3FF, pattern[i]);
    endtask

    task automatic look(input logic [31:0] pc);
        drive(pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
        #20;
        rst = 1'b0;
        #1;
        chk("reset_idx", 32'(bp.pht_idx_if), 32'h041);
        chk("reset_pred", 32'(bp.pred_taken_if), 32'h0);
`ifdef GSHARE_STATS_EN
        chk("reset_stat_lookups", stat_lookups, 32'h0);
`endif
        @(negedge clk);

        // Train entry 0x041 up to strongly taken, then saturate.
        upd_only(10'h041, 1'b1);
        upd_only(10'h041, 1'b1);
        look(32'h104);
        chk("two_taken_pred", 32'(bp.pred_taken_if), 32'h1);
        upd_only(10'h041, 1'b1);
        for (int i = 0; i < 4; i++) upd_only(10'h041, 1'b0);
        look(32'h104);
        chk("four_nt_pred", 32'(bp.pred_taken_if), 32'h0);

        // Predictions 1,0,1 build spec_ghr = 0b101.
        upd_only(10'h100, 1'b1);
        upd_only(10'h100, 1'b1);
        step(32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
        step(32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
        step(32'h408, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
        look(32'h104);
        chk("spec_101_idx", 32'(bp.pht_idx_if), 32'h044);
        step(32'h408, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
        look(32'h104);
        chk("stall_no_shift_idx", 32'(bp.pht_idx_if), 32'h044);

        // Mispredict repair beats a same-cycle IF shift.
        load_arch(10'b0000000011);
        step(32'h104, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0);
        look(32'h104);
        chk("mispred_repair_idx", 32'(bp.pht_idx_if), 32'h047);

        // Flush repair includes the same-cycle correct update.
        load_arch(10'b0000000010);
        step(32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b1);
        look(32'h104);
        chk("flush_repair_idx", 32'(bp.pht_idx_if), 32'h044);

        // Random traffic over a small PC window so entries collide.
        for (int n = 0; n < 500; n++) begin
            step({20'h0, 6'($urandom_range(0, 63)), 6'h0} | {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                 1'($urandom % 2), 1'($urandom % 4 == 0),
                 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 4 == 0),
                 10'($urandom_range(0, 127)), 1'($urandom % 16 == 0));
        end

        // Asynchronous reset mid-operation.
        drive(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_reset_idx", 32'(bp.pht_idx_if), 32'h041);
        chk("async_reset_pred", 32'(bp.pred_taken_if), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(32'h104, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h041, 1'b0);
        step(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_gshare_spec.md
Name: branch_gshare_spec

Overview:
- Parametrised next-generation GShare direction predictor for the in-order CPU fetch path.
- IF indexes a pattern history table (PHT) of saturating counters with PC bits XOR a speculative global history register (GHR). The speculative GHR shifts in each prediction at IF.
- EX trains the PHT, maintains an architectural GHR, and repairs the speculative GHR on mispredict or pipeline flush.
- Sits between the PC generator (IF) and branch resolution (EX). The PHT index travels down the pipe with the instruction.

Parameters:
- PC_LSB, 2: lowest PC bit used for indexing (word-aligned fetch).
- IDX_W, 10: PHT index width; PHT depth = 2**IDX_W.
- HIST_W, 10: GHR length; legal 1..IDX_W. History is zero-extended and XORed into the low index bits.
- CNT_W, 2: counter width; legal 2..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_if  in  32  fetch PC
- if_br_valid  in  1  fetch slot holds a branch-like instruction; a prediction is consumed
- if_stall  in  1  IF held this cycle; prediction not consumed
- pred_taken_if  out  1  predicted direction (counter MSB)
- pht_idx_if  out  IDX_W  index, carried to EX
- ex_update_en  in  1  resolved branch-like instruction in EX
- ex_actual_taken  in  1  resolved outcome
- ex_mispredict  in  1  direction mispredicted (qualified by ex_update_en)
- pht_idx_ex  in  IDX_W  index carried from IF
- flush  in  1  non-branch pipeline flush (trap/exception)

Behaviour:
- Reset (async):
  - Every counter = 2**(CNT_W-1)-1 (weak not-taken).
  - spec_ghr = 0, arch_ghr = 0.
  - Hence pred_taken_if = 0 and pht_idx_if = pc_if[PC_LSB+IDX_W-1:PC_LSB] immediately after reset.
- IF (combinational, 0 latency):
  - pht_idx_if = pc_if[PC_LSB+IDX_W-1:PC_LSB] ^ zext(spec_ghr).
  - pred_taken_if = pht[pht_idx_if][CNT_W-1].
  - No write-to-read bypass: a same-cycle EX write to the same entry is not visible to IF until the next cycle.
- Speculative shift: on if_br_valid && !if_stall, spec_ghr <= {spec_ghr[HIST_W-2:0], pred_taken_if}. For HIST_W=1, spec_ghr <= pred_taken_if.
- EX training (ex_update_en=1):
  - pht[pht_idx_ex] saturating +1 if taken, -1 if not taken.
  - Saturates at 2**CNT_W-1 and at 0; no change when saturated.
  - arch_ghr <= {arch_ghr[HIST_W-2:0], ex_actual_taken}.
- ex_mispredict without ex_update_en is ignored.
- Repair, priority highest first within one cycle:
  - (1) ex_update_en && ex_mispredict: spec_ghr <= {arch_ghr[HIST_W-2:0], ex_actual_taken}, i.e. the new arch_ghr value.
  - (2) flush: spec_ghr <= new arch_ghr value; the same-cycle EX update is included if present.
  - (3) IF speculative shift.
  - A repair discards any same-cycle IF shift.
- In-order resolution is required, so arch_ghr is exact history at EX. No snapshot port is needed.
- Reset asserted mid-operation: all state returns to reset values asynchronously; in-flight pht_idx values are meaningless afterwards.
- Simultaneous IF shift and non-mispredict EX update: both happen. arch_ghr and spec_ghr update independently.

Optional Feature:
- Macro GSHARE_STATS_EN.
- When defined, adds three outputs, each reset to 0 and wrapping at 2**32:
  - stat_lookups (out, 32): +1 per consumed prediction.
  - stat_updates (out, 32): +1 per ex_update_en.
  - stat_mispredicts (out, 32): +1 per ex_update_en && ex_mispredict.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package branch_pred_pkg:
  - counter reset-value function.
  - saturating inc/dec function, parametrised by CNT_W.
  - enum/constants for history update source (NONE, SPEC, MISPRED, FLUSH).
- Sub-module gshare_pht:
  - Counter array with one async read port (IF) and one read-modify-write update port (EX).
  - Contains the reset loop and saturation logic.
- Top level holds both GHRs, the repair priority mux, index hash and optional stats.

Test Plan:
- Reset, pc_if=0x0000_0104, defaults -> pred_taken_if=0, pht_idx_if=0x041, spec_ghr=0.
- Two EX updates taken at idx 0x041, no IF branches -> counter 1->2->3. Lookup at pc 0x104 -> pred_taken_if=1. Third taken update keeps counter at 3.
- Four not-taken updates on that entry -> counter 3->2->1->0->0 (saturation). Prediction flips to 0 after the second update.
- Three IF branches predicted 1,0,1 with if_stall=0 -> spec_ghr=0b101, pht_idx_if = pc bits ^ 0x005. One of them repeated with if_stall=1 -> no shift.
- arch_ghr=0b011, EX mispredict actual=0, simultaneous IF branch -> spec_ghr=0b0110 (IF shift discarded), arch_ghr=0b0110.
- flush with arch_ghr=0b10, same-cycle correct update actual=1 -> spec_ghr=0b101. With GSHARE_STATS_EN, stat_updates +1 and stat_mispredicts unchanged.
